dot_product_sequencer: RTL

Control block that runs one complete dot product on the parallel dot-product datapath (the `DotProductSt` multiply/3-way-interleaved-accumulate unit). On a `start` pulse it:
- clears the datapath accumulators;
- streams pixel/weight words from a synchronous 1-cycle-latency buffer;
- zero-gates the buses while the FPM/FPA pipelines drain;
- captures the final sum with a one-cycle valid pulse.

It sits between the layer controller and each datapath instance.

---
 rtl/dot_product_sequencer_if.sv | 28 ++
 rtl/dot_product_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer_if.sv
// Buffer-read and datapath bus between dot_product_sequencer and its
// pixel/weight buffer plus DotProductSt datapath instance.
// master: sequencer side; slave: buffer/datapath side.
interface dot_product_sequencer_if #(
    parameter int ADDR_W    = 8,
    parameter int PIX_BUS_W = 20,
    parameter int WGT_BUS_W = 38,
    parameter int VAL_SIZE  = 26
);
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [PIX_BUS_W-1:0] mem_pixels;
    logic [WGT_BUS_W-1:0] mem_weights;
    logic                 dp_clear;
    logic [PIX_BUS_W-1:0] dp_pixels;
    logic [WGT_BUS_W-1:0] dp_weights;
    logic [VAL_SIZE-1:0]  value_in;

    modport master (
        output rd_en, rd_addr, dp_clear, dp_pixels, dp_weights,
        input  mem_pixels, mem_weights, value_in
    );

    modport slave (
        input  rd_en, rd_addr, dp_clear, dp_pixels, dp_weights,
        output mem_pixels, mem_weights, value_in
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: runs one dot product on the DotProductSt datapath.
// IDLE -> CLEAR(2) -> FEED(WORDS*BUS_WIDTH) -> DRAIN(FPM+FPA+6) -> CAPTURE(1).
// Optional macro DPSEQ_BACK2BACK_EN: accept start during CAPTURE and go
// straight to CLEAR for the next job, keeping busy high.
module dot_product_sequencer #(
    parameter int PIXEL_N     = 10,
    parameter int PARALLEL    = 2,
    parameter int BUS_WIDTH   = 1,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int FPM_DELAY   = 6,
    parameter int FPA_DELAY   = 2,
    parameter int VAL_SIZE    = 26,
    parameter int ADDR_W      = 8
) (
    input  logic                 clk,
    input  logic                 GlobalReset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 busy,
    dot_product_sequencer_if.master bus,
    output logic [VAL_SIZE-1:0]  result,
    output logic                 result_valid
);
    localparam int LANES   = PARALLEL * BUS_WIDTH;
    localparam int WORDS   = (PIXEL_N + LANES - 1) / LANES;
    localparam int FEED    = WORDS * BUS_WIDTH;
    localparam int DRAIN   = FPM_DELAY + FPA_DELAY + 6;
    localparam int CNT_MAX = (FEED > DRAIN) ? FEED : DRAIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PIX_W   = LANES * PIXEL_SIZE;
    localparam int WGT_W   = LANES * WEIGHT_SIZE;

    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(1);
    localparam logic [CNT_W-1:0] FEED_LOAD  = CNT_W'(FEED - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_CAPTURE
    } state_t;

    state_t            state, state_n;
    logic              accept;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_en_c;
    logic              dp_clear_q;
    logic              feed_valid;
    logic [PIX_W-1:0]  gated_pix;
    logic [WGT_W-1:0]  gated_wgt;

    // State register.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) state <= S_IDLE;
        else             state <= state_n;
    end

    // Next-state logic; accept marks the cycle a start is taken.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLEAR;
                    accept  = 1'b1;
                end
            end
            S_CLEAR:   if (cnt == '0) state_n = S_FEED;
            S_FEED:    if (cnt == '0) state_n = S_DRAIN;
            S_DRAIN:   if (cnt == '0) state_n = S_CAPTURE;
            S_CAPTURE: begin
`ifdef DPSEQ_BACK2BACK_EN
                if (start) begin
                    state_n = S_CLEAR;
                    accept  = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
`else
                state_n = S_IDLE;
`endif
            end
            default:   state_n = S_IDLE;
        endcase
    end

    // Output decode. In FEED the counter runs FEED-1..0 and FEED is a
    // multiple of BUS_WIDTH, so cnt%BUS_WIDTH==0 marks the last beat of a
    // word; cnt==0 is the last word, which needs no follow-on read.
    always_comb begin
        busy    = (state != S_IDLE);
        rd_en_c = 1'b0;
        if (state == S_CLEAR && cnt == '0)
            rd_en_c = 1'b1;
        else if (state == S_FEED && cnt != '0 && (int'(cnt) % BUS_WIDTH) == 0)
            rd_en_c = 1'b1;
    end

    // Shared phase timer, reloaded on every state entry.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            cnt <= '0;
        end else if (state_n != state) begin
            case (state_n)
                S_CLEAR: cnt <= CLEAR_LOAD;
                S_FEED:  cnt <= FEED_LOAD;
                S_DRAIN: cnt <= DRAIN_LOAD;
                default: cnt <= '0;
            endcase
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Read address: loaded from base_addr on accept, stepped per read.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset)  rd_addr_q <= '0;
        else if (accept)  rd_addr_q <= base_addr;
        else if (rd_en_c) rd_addr_q <= rd_addr_q + 1'b1;
    end

    // Registered datapath clear and bus gate, decoded from the next state
    // so they line up exactly with the CLEAR/IDLE and FEED cycles.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            dp_clear_q <= 1'b1;
            feed_valid <= 1'b0;
        end else begin
            dp_clear_q <= (state_n == S_IDLE) || (state_n == S_CLEAR);
            feed_valid <= (state_n == S_FEED);
        end
    end

    // Capture value_in on the edge entering CAPTURE so result is already
    // updated while result_valid is high.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= (state_n == S_CAPTURE);
            if (state_n == S_CAPTURE) result <= bus.value_in;
        end
    end

    assign gated_pix      = feed_valid ? bus.mem_pixels  : '0;
    assign gated_wgt      = feed_valid ? bus.mem_weights : '0;
    assign bus.dp_pixels  = gated_pix;
    assign bus.dp_weights = gated_wgt;
    assign bus.rd_en      = rd_en_c;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.dp_clear   = dp_clear_q;
endmodule
